// File: rtl/dpreg_wr_arb_if.sv
// dpreg_wr_arb_if: request/ack handshake and datapath-register signals of the write arbiter
interface dpreg_wr_arb_if #(parameter int WIDTH = 32, parameter int NREQ = 4, parameter int CNTW = 8);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      dout;
    logic                  load;
    logic                  busy;
    logic [2:0]            gidx;
    logic [CNTW-1:0]       wcnt;
    modport master (output req, wdata, input ack, dout, load, busy, gidx, wcnt);
    modport slave  (input req, wdata, output ack, dout, load, busy, gidx, wcnt);
endinterface

// File: rtl/dpreg_wr_arb.sv
// dpreg_wr_arb: round-robin write arbiter/sequencer for a shared datapath register.
// Optional DPREG_WR_ARB_PRIO0_EN gives requester 0 fixed highest priority.
module dpreg_wr_arb #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int CNTW  = 8
) (
    input logic           clk,
    input logic           clr,
    dpreg_wr_arb_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACKW} state_t;
    state_t            state, state_n;
    logic [IW-1:0]     ptr, ptr_n, gsel, gsel_n, win, idx, nxt;
    logic              found, load, load_n, busy;
    logic [NREQ-1:0]   ack, ack_n;
    logic [WIDTH-1:0]  dout, dout_n;
    logic [CNTW-1:0]   wcnt, wcnt_n;

    // first requesting index at or after ptr, with wrap
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
`ifdef DPREG_WR_ARB_PRIO0_EN
        found = bus.req[0];
`endif
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign nxt = (gsel == IW'(NREQ - 1)) ? '0 : gsel + 1'b1;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gsel_n  = gsel;
        dout_n  = dout;
        load_n  = 1'b0;
        ack_n   = ack;
        wcnt_n  = wcnt;
        case (state)
            S_IDLE: if (found) begin
                gsel_n  = win;
                dout_n  = bus.wdata[int'(win)*WIDTH +: WIDTH];
                load_n  = 1'b1;
                state_n = S_LOAD;
            end
            S_LOAD: begin
                ack_n   = NREQ'(1) << gsel;
                wcnt_n  = wcnt + 1'b1;
                state_n = S_ACKW;
            end
            S_ACKW: if (!bus.req[gsel]) begin
                ack_n   = '0;
                state_n = S_IDLE;
`ifdef DPREG_WR_ARB_PRIO0_EN
                if (gsel != '0) ptr_n = nxt;
`else
                ptr_n = nxt;
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
            ptr   <= '0;
            gsel  <= '0;
            dout  <= '0;
            load  <= 1'b0;
            ack   <= '0;
            wcnt  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            gsel  <= gsel_n;
            dout  <= dout_n;
            load  <= load_n;
            ack   <= ack_n;
            wcnt  <= wcnt_n;
            busy  <= state_n != S_IDLE;
        end
    end

    assign bus.ack  = ack;
    assign bus.dout = dout;
    assign bus.load = load;
    assign bus.busy = busy;
    assign bus.gidx = 3'(gsel);
    assign bus.wcnt = wcnt;
endmodule

// File: tb/tb_dpreg_wr_arb.sv
// tb_dpreg_wr_arb: vector table of arbitration rounds plus hold, abort and counter-wrap sequences.
module tb_dpreg_wr_arb;
    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   passed = 0;
    int   tcnt = 0;
    logic [7:0] wcnt_m = 8'd0;

    typedef struct { logic [3:0] mask; int exp; } vec_t;
    typedef struct { logic [2:0] gidx; logic [31:0] dout; } sb_t;
    vec_t vt[12];
    sb_t  sbq[$];

    dpreg_wr_arb_if #(.WIDTH(32), .NREQ(4), .CNTW(8)) bus();
    dpreg_wr_arb #(.WIDTH(32), .NREQ(4), .CNTW(8)) dut (.clk(clk), .clr(clr), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_load(input string name, output bit ok);
        int n = 0;
        @(negedge clk);
        while (bus.load !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.load === 1'b1);
        if (!ok) begin
            total++;
            $display("FAIL %s: load not seen within 10 cycles", name);
        end
    endtask

    // one full four-phase write by the requesters in mask; exp must win
    task automatic xact(input logic [3:0] mask, input int exp);
        sb_t e;
        bit  ok;
        for (int i = 0; i < 4; i++) bus.wdata[i*32 +: 32] = {8'hA5, 8'(tcnt), 8'h00, 8'(i)};
        sbq.push_back('{3'(exp), {8'hA5, 8'(tcnt), 8'h00, 8'(exp)}});
        tcnt++;
        bus.req = mask;
        wait_load("xact_load", ok);
        e = sbq.pop_front();
        if (!ok) begin
            bus.req = '0;
            repeat (4) @(negedge clk);
            return;
        end
        chk("gidx", bus.gidx, e.gidx);
        chk("dout", bus.dout, e.dout);
        wcnt_m++;
        @(negedge clk);
        chk("load_one_cycle", bus.load, 1'b0);
        chk("ack_onehot", bus.ack, 4'(1) << exp);
        chk("wcnt", bus.wcnt, wcnt_m);
        chk("busy_ackw", bus.busy, 1'b1);
        bus.req[exp] = 1'b0;
        @(negedge clk);
        chk("ack_release", bus.ack, 4'b0);
        chk("busy_idle", bus.busy, 1'b0);
    endtask

    initial begin
        bit  ok;
        sb_t e;
`ifdef DPREG_WR_ARB_PRIO0_EN
        vt = '{'{4'b1111,0}, '{4'b1110,1}, '{4'b1100,2}, '{4'b1000,3}, '{4'b1111,0}, '{4'b0110,1},
               '{4'b1001,0}, '{4'b1001,0}, '{4'b1001,0}, '{4'b0101,0}, '{4'b0101,0}, '{4'b0011,0}};
`else
        vt = '{'{4'b1111,0}, '{4'b1110,1}, '{4'b1100,2}, '{4'b1000,3}, '{4'b1111,0}, '{4'b0110,1},
               '{4'b1001,3}, '{4'b1001,0}, '{4'b1001,3}, '{4'b0101,0}, '{4'b0101,2}, '{4'b0011,0}};
`endif
        clr = 1'b1;
        bus.req = 4'b1111;
        bus.wdata = '1;
        repeat (2) @(negedge clk);
        chk("rst_ack", bus.ack, 4'b0);
        chk("rst_load", bus.load, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_dout", bus.dout, 32'h0);
        chk("rst_gidx", bus.gidx, 3'd0);
        chk("rst_wcnt", bus.wcnt, 8'd0);
        clr = 1'b0;
        for (int v = 0; v < 12; v++) xact(vt[v].mask, vt[v].exp);

        // requester 2 keeps REQ high for 10 cycles after ACK
        bus.wdata[64 +: 32] = 32'hA5A5_0002;
        sbq.push_back('{3'd2, 32'hA5A5_0002});
        bus.req = 4'b0100;
        wait_load("hold_load", ok);
        e = sbq.pop_front();
        if (ok) begin
            chk("hold_gidx", bus.gidx, e.gidx);
            chk("hold_dout", bus.dout, e.dout);
            wcnt_m++;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                chk("hold_ack", bus.ack, 4'b0100);
                chk("hold_noload", bus.load, 1'b0);
            end
            chk("hold_wcnt", bus.wcnt, wcnt_m);
            bus.req = 4'b0;
            @(negedge clk);
            chk("hold_ack_drop", bus.ack, 4'b0);
            chk("hold_busy_drop", bus.busy, 1'b0);
        end

        // reset while LOAD is high aborts the write
        bus.wdata[32 +: 32] = 32'h1234_5678;
        bus.req = 4'b0010;
        wait_load("abort_load", ok);
        #1 clr = 1'b1;
        #1;
        chk("abort_load", bus.load, 1'b0);
        chk("abort_ack", bus.ack, 4'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_wcnt", bus.wcnt, 8'd0);
        @(negedge clk);
        clr = 1'b0;
        wcnt_m = 8'd0;
        xact(4'b0010, 1);

        // counter wraps 255 -> 0
        while (wcnt_m != 8'hFF) xact(4'b1000, 3);
        xact(4'b1000, 3);
        chk("wcnt_wrap", bus.wcnt, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
